// File: rtl/fpu_ret_pkg.sv
// Shared definitions for the FPU retire/exception collector.
// Flag bit positions, default widths and the nominal retire-entry layout.
package fpu_ret_pkg;

  localparam int FLG_INV = 0;
  localparam int FLG_DZ  = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 3;
  localparam int FLG_INX = 4;
  localparam int NUM_FLG = FLG_INX + 1;

  localparam int RET_W_DEF   = 14;
  localparam int RAISE_W_DEF = 11;
  localparam int LANE_W_MAX  = 3;

  typedef struct packed {
    logic [RET_W_DEF-1:0]  ret;
    logic [LANE_W_MAX-1:0] lane;
  } ret_entry_t;

  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/fpu_ret_compact.sv
// Lane compaction: per-lane slot offsets, free-space-limited accepts and
// accepted count for one cycle of retire pushes. Purely combinational.
module fpu_ret_compact #(
  parameter int LANES = 3,
  parameter int CNT_W = 4
) (
  input  logic [LANES-1:0]       en,
  input  logic [CNT_W-1:0]       free,
  output logic [LANES*CNT_W-1:0] offs,
  output logic [LANES-1:0]       accept,
  output logic [CNT_W-1:0]       acc_cnt,
  output logic                   drop
);

  logic [CNT_W-1:0] run;

  // run counts enabled lanes below lane i; lowest lanes win when space is short
  always_comb begin
    run     = '0;
    offs    = '0;
    accept  = '0;
    acc_cnt = '0;
    drop    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      offs[i*CNT_W +: CNT_W] = run;
      if (en[i]) begin
        if (run < free) begin
          accept[i] = 1'b1;
          acc_cnt   = acc_cnt + CNT_W'(1);
        end else begin
          drop = 1'b1;
        end
        run = run + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fpu_ret_collect.sv
// Retire/exception collector: packs valid lane retire words into a FIFO in
// lane order, drains one per cycle, and keeps sticky IEEE exception flags.
module fpu_ret_collect
  import fpu_ret_pkg::*;
#(
  parameter int LANES   = 3,
  parameter int DEPTH   = 8,
  parameter int RET_W   = RET_W_DEF,
  parameter int RAISE_W = RAISE_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES*RET_W-1:0]       lane_ret,
  input  logic [LANES-1:0]             lane_ret_en,
  input  logic [LANES*RAISE_W-1:0]     lane_raise,
  output logic [RET_W-1:0]             ret_out,
  output logic [lane_width(LANES)-1:0] ret_lane,
  output logic                         ret_valid,
  input  logic                         ret_ready,
  output logic                         stall,
  output logic [4:0]                   flags,
  input  logic                         flags_clr,
  output logic                         overflow_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = lane_width(LANES);

  generate
    if (LANES < 1 || LANES > 8 || DEPTH < 2 * LANES || (DEPTH & (DEPTH - 1)) != 0
        || RAISE_W < NUM_FLG) begin : g_bad_params
      $error("fpu_ret_collect: illegal LANES/DEPTH/RAISE_W combination");
    end
  endgenerate

  typedef struct packed {
    logic [RET_W-1:0]  ret;
    logic [LANE_W-1:0] lane;
  } entry_t;

  entry_t                  mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic [CNT_W-1:0]        free;
  logic                    pop;
  logic [LANES*CNT_W-1:0]  offs;
  logic [LANES-1:0]        accept;
  logic [CNT_W-1:0]        acc_cnt;
  logic                    drop;
  logic [NUM_FLG-1:0]      raise_or;

  assign ret_valid  = (count != '0);
  assign pop        = ret_valid & ret_ready;
  assign free       = CNT_W'(DEPTH) - count + CNT_W'(pop);
  assign count_next = count + acc_cnt - CNT_W'(pop);

  // Head is gated so an empty FIFO never exposes stale storage
  assign ret_out  = ret_valid ? mem[rd_ptr].ret  : '0;
  assign ret_lane = ret_valid ? mem[rd_ptr].lane : '0;

  fpu_ret_compact #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_compact (
    .en      (lane_ret_en),
    .free    (free),
    .offs    (offs),
    .accept  (accept),
    .acc_cnt (acc_cnt),
    .drop    (drop)
  );

  // Dropped lanes still contribute their raise bits
  always_comb begin
    raise_or = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_ret_en[i]) begin
        raise_or = raise_or | lane_raise[i*RAISE_W +: NUM_FLG];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (accept[i]) begin
        mem[wr_ptr + offs[i*CNT_W +: PTR_W]] <= '{ret:  lane_ret[i*RET_W +: RET_W],
                                                  lane: LANE_W'(i)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      flags        <= '0;
      overflow_err <= 1'b0;
      stall        <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(acc_cnt);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count_next;
      flags  <= (flags & ~{NUM_FLG{flags_clr}}) | raise_or;
      if (drop) begin
        overflow_err <= 1'b1;
      end
      stall <= (CNT_W'(DEPTH) - count_next) < CNT_W'(LANES);
    end
  end

endmodule

// File: doc/fpu_ret_collect.md
# fpu_ret_collect

Parametrised retire/exception collector for an FPU cluster of `LANES` lanes. Each cycle, every lane may present one 14-bit retire word and an 11-bit raise vector. The block packs the valid retire words into a FIFO in lane order, drains them one per cycle through a valid/ready port, and keeps sticky IEEE exception flags. It sits between the FPU lane outputs and the retire unit, and replaces the fixed three-lane ret/raise plumbing with a width- and depth-generic buffered path.

## Interface
Parameters:
- `LANES`, 3, number of FPU lanes (1..8).
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2·`LANES`; checked at elaboration.
- `RET_W`, 14, retire word width.
- `RAISE_W`, 11, per-lane raise vector width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `lane_ret` in `LANES*RET_W`: retire words; lane i occupies `[i*RET_W +: RET_W]`.
- `lane_ret_en` in `LANES`: per-lane retire valid.
- `lane_raise` in `LANES*RAISE_W`: per-lane raise vectors; only bits [4:0] are used.
- `ret_out` out `RET_W`: head retire word.
- `ret_lane` out `$clog2(LANES)` (min 1): source lane of the head entry.
- `ret_valid` out 1: FIFO is not empty.
- `ret_ready` in 1: the consumer accepts the head.
- `stall` out 1: free entries < `LANES`; tells issue to hold the lanes.
- `flags` out 5: sticky {inexact, underflow, overflow, divzero, invalid}, with invalid at bit 0.
- `flags_clr` in 1: clears `flags`.
- `overflow_err` out 1: sticky; a retire word was dropped.

## Operation
- Pushes per cycle:
  - push count k = popcount(`lane_ret_en`).
  - Lane i writes to slot wr_ptr + (number of enabled lanes below i).
  - Lane order is preserved within a cycle and across cycles.
- Pop: occurs when `ret_valid && ret_ready`. The head is read combinationally from the storage array.
- Free space for the cycle is `DEPTH - count + pop`, so a same-cycle pop frees one slot for pushes.
- Overflow:
  - If k exceeds the free space, the lowest-indexed enabled lanes are accepted up to the free space.
  - The remaining lanes are dropped.
  - `overflow_err` is set and is cleared only by reset.
- Counters and pointers:
  - `count_next = count + accepted - pop`.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Flags:
  - `flags_next = (flags & ~{5{flags_clr}}) | OR over enabled lanes of lane_raise[4:0]`.
  - Raise bits from lanes with `lane_ret_en` low are ignored.
  - A raise in the same cycle as `flags_clr` wins, so the new bits end up set.
  - Flags from dropped lanes are still accumulated.
- `stall` is registered: `stall <= (DEPTH - count_next) < LANES`.

## Timing
- Reset (`rst` low, asynchronous, may assert at any time): `ret_valid`=0, `ret_out`=0, `ret_lane`=0, `stall`=0, `flags`=0, `overflow_err`=0, pointers and count = 0. Entries in flight are discarded.
- Push-to-valid latency is 1 cycle: a word presented in cycle N is visible at the head in cycle N+1 at the earliest.
- Pop throughput is one per cycle; `ret_out` advances on the edge following acceptance.
- `ret_out`/`ret_lane` must be held stable while `ret_valid && !ret_ready`.
- Empty FIFO: a push in the same cycle makes `ret_valid` rise the next cycle. There is no fall-through bypass.
- Full FIFO with a pop: up to one push is accepted in that cycle.
- `stall` reflects post-edge occupancy. Lanes that ignore `stall` are handled by the overflow rule.

## Structure
- Shared package `fpu_ret_pkg` holds:
  - flag bit indices (`FLG_INV`, `FLG_DZ`, `FLG_OVF`, `FLG_UNF`, `FLG_INX`);
  - default `RET_W`/`RAISE_W`;
  - the `ret_entry_t` struct {ret, lane}.
- Sub-module `fpu_ret_compact` is combinational. It computes per-lane prefix offsets, per-lane accept bits limited by free space, and the accepted count.
- Top level holds the storage array, pointers, count, flags and the stall register.

## Test plan
- Reset mid-operation: 5 entries queued and flags=5'b10101, then drop `rst` asynchronously → every output is 0 immediately; after release, `ret_valid` stays 0 until the next push.
- Full-width push: lanes 0/1/2 carry 14'h0011/14'h0022/14'h0033 with `ret_ready`=0, then `ret_ready`=1 → `ret_valid` rises next cycle; pops yield 0x0011/L0, 0x0022/L1, 0x0033/L2 on consecutive cycles.
- Sparse push: only lanes 0 and 2 enabled (0x0AAA, 0x0CCC) → two entries in order 0x0AAA/L0, 0x0CCC/L2, with no gap entry.
- Fill/overflow (DEPTH=8, `ret_ready`=0, all lanes pushing each cycle):
  - after 2 cycles count=6 and `stall`=1;
  - on the third push, lanes 0 and 1 are accepted and lane 2 is dropped;
  - count=8 and `overflow_err`=1.
- Flags:
  - lane 1 raise 11'h004 → `flags`=5'b00100;
  - next cycle, `flags_clr` together with lane 0 raise 11'h001 → `flags`=5'b00001;
  - a raise with `lane_ret_en`=0 → no change.
- Wrap and concurrency: 40 random push patterns with `ret_ready` toggling, including simultaneous push+pop at full → output order matches a scoreboard model, and no drops occur while `stall` is honoured.
